// File: rtl/sum4_controller.sv
// Streaming word summer: after start, accumulates WORDS unsigned words over a
// valid/ready input, then holds the sum on a valid/ready output until taken.
//
// state   | meaning
// S_IDLE  | waiting for start; no input accepted, no sum offered
// S_ACCUM | accepting words into r_acc, r_cnt counts accepted words
// S_DONE  | offering r_acc as sum_data until sum_ready (or abort)
module sum4_controller #(
  parameter  int WIDTH = 8,
  parameter  int WORDS = 4,
  localparam int CNT_W = $clog2(WORDS),
  localparam int SUM_W = WIDTH + CNT_W
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum_data,
  input  logic             sum_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_xfer;
  logic             w_last;
  logic             w_restart;

  // in_ready is a pure decode of state, so the transfer needs only the state
  assign w_xfer    = (r_state == S_ACCUM) && in_valid;
  assign w_last    = (r_cnt == CNT_W'(WORDS - 1));
  assign w_restart = start && ((r_state == S_IDLE) ||
                               ((r_state == S_DONE) && sum_ready));

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (abort || w_restart) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_acc <= r_acc + SUM_W'(in_data);
        r_cnt <= r_cnt + CNT_W'(1);  // wraps to 0 on the last word
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_next_state = S_ACCUM;
        S_ACCUM: if (w_xfer && w_last) w_next_state = S_DONE;
        S_DONE:  if (sum_ready) w_next_state = start ? S_ACCUM : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    sum_data  = '0;
    busy      = 1'b0;
    unique case (r_state)
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        sum_valid = 1'b1;
        sum_data  = r_acc;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sum4_controller.sv
// Bench for sum4_controller: the driver pushes each run's expected sum into a
// queue, and a negedge monitor pops and compares whenever a sum is offered.
module tb_sum4_controller;

  logic       clk = 1'b0;
  logic       sync_reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       sum_valid;
  logic [9:0] sum_data;
  logic       sum_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  bit have_cur = 1'b0;
  int cur = 0;

  sum4_controller dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sum_valid (sum_valid),
    .sum_data  (sum_data),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees a stable cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (sum_valid) begin
        if (!have_cur) begin
          chk("sum_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("sum_data", sum_data, cur);
          end
        end else begin
          chk("sum_stable", sum_data, cur);
        end
        if (sum_ready || abort || sync_reset) have_cur = 1'b0;
      end else begin
        chk("sum_zero_when_idle", sum_data, 0);
        chk("valid_dropped_early", have_cur, 0);
        have_cur = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_sum_valid"}, sum_valid, 0);
    chk({tag, "_sum_data"}, sum_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
  endtask

  // Present the run's words; abort_at >= 0 aborts while that word is offered
  task automatic feed(input int w[4], input int max_gap, input int abort_at);
    int s = 0;
    foreach (w[k]) s += w[k];
    for (int i = 0; i < 4; i++) begin
      int gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = 1'($urandom_range(1, 0));
        tick();
        chk("gap_in_ready", in_ready, 1);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'(w[i]);
      chk("word_in_ready", in_ready, 1);
      if (i == abort_at) begin
        abort = 1'b1;
        start = 1'($urandom_range(1, 0));
        tick();
        abort = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check_all_zero("abort");
        return;
      end
      if (i == 3) exp_q.push_back(s);
      tick();
      in_valid = 1'b0;
    end
    chk("latency_sum_valid", sum_valid, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 1);
  endtask

  // Hold the sum for 'hold' cycles, then take it (optionally restarting) or abort
  task automatic finish(input int hold, input bit restart, input bit abort_in_done);
    repeat (hold) begin
      sum_ready = 1'b0;
      start     = 1'($urandom_range(1, 0));
      in_valid  = 1'($urandom_range(1, 0));
      in_data   = 8'($urandom);
      tick();
      chk("hold_sum_valid", sum_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    if (abort_in_done) begin
      abort = 1'b1;
      sum_ready = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      sum_ready = 1'b0;
      start = 1'b0;
      check_all_zero("done_abort");
      return;
    end
    sum_ready = 1'b1;
    start = restart;
    tick();
    sum_ready = 1'b0;
    start = 1'b0;
    if (restart) begin
      chk("b2b_in_ready", in_ready, 1);
      chk("b2b_sum_valid", sum_valid, 0);
    end else begin
      check_all_zero("post_take");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w[4];
    bit in_accum;

    sync_reset = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    tick();
    tick();
    sync_reset = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    check_all_zero("reset");
    mon_en = 1'b1;

    // basic sum 10+20+30+40
    do_start();
    w = '{10, 20, 30, 40};
    feed(w, 0, -1);
    finish(0, 1'b0, 1'b0);

    // maximum sum, no wrap
    do_start();
    w = '{255, 255, 255, 255};
    feed(w, 0, -1);
    finish(1, 1'b0, 1'b0);

    // stalls on both sides
    do_start();
    w = '{11, 22, 33, 44};
    feed(w, 2, -1);
    finish(3, 1'b0, 1'b0);

    // abort with a third word presented, then a clean run
    do_start();
    w = '{5, 6, 7, 8};
    feed(w, 0, 2);
    do_start();
    w = '{1, 2, 3, 4};
    feed(w, 0, -1);
    finish(0, 1'b0, 1'b0);

    // back-to-back handoff
    do_start();
    w = '{9, 9, 9, 9};
    feed(w, 0, -1);
    finish(1, 1'b1, 1'b0);
    w = '{1, 1, 1, 1};
    feed(w, 0, -1);
    finish(0, 1'b0, 1'b0);

    // reset after three words, with abort also high
    do_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'd50;
      tick();
    end
    in_valid = 1'b0;
    sync_reset = 1'b1;
    abort = 1'b1;
    tick();
    sync_reset = 1'b0;
    abort = 1'b0;
    check_all_zero("midrun_reset");
    do_start();
    w = '{2, 2, 2, 2};
    feed(w, 0, -1);
    finish(0, 1'b0, 1'b0);

    // reset while a sum is offered
    do_start();
    w = '{100, 1, 1, 1};
    feed(w, 0, -1);
    sync_reset = 1'b1;
    sum_ready = 1'b1;
    tick();
    sync_reset = 1'b0;
    sum_ready = 1'b0;
    check_all_zero("done_reset");

    // randomized runs
    in_accum = 1'b0;
    for (int r = 0; r < 60; r++) begin
      int abort_at;
      bit restart;
      if (!in_accum) do_start();
      foreach (w[k]) w[k] = ($urandom_range(3, 0) == 0) ? 255 : int'($urandom_range(255, 0));
      abort_at = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      feed(w, 2, abort_at);
      if (abort_at >= 0) begin
        in_accum = 1'b0;
      end else begin
        restart = 1'($urandom_range(1, 0));
        if ($urandom_range(9, 0) == 0) begin
          finish($urandom_range(3, 0), 1'b0, 1'b1);
          in_accum = 1'b0;
        end else begin
          finish($urandom_range(3, 0), restart, 1'b0);
          in_accum = restart;
        end
      end
    end
    if (in_accum) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_all_zero("final_abort");
    end

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
